// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
// Decode-stage register file with two registered read ports, one write port,
// an optional hardwired-zero register 0 and a per-register pending scoreboard.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read that collides with a same-cycle write captures WriteData,
//               and captures the post-edge pending bit for that register.
//   undefined : a colliding read captures the old contents and old pending bit.
// ---------------------------------------------------------------------------
module register_file_sb #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int R0_ZERO = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ReadEnable1,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic             ReadEnable2,
    input  logic [AW-1:0]    ReadRegister2,
    input  logic             WriteEnable,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             Reserve,
    input  logic [AW-1:0]    ReserveRegister,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Pending1,
    output logic             Pending2,
    output logic             AnyPending
);

    // Register storage and scoreboard state
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] res_hit;

    // Per-register write / reserve decode and storage
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        // Register 0 is inert when hardwired to zero: it never accepts a
        // write or a reservation, so its storage and pending bit stay 0.
        localparam bit IS_ZERO = (R0_ZERO != 0) && (gi == 0);

        assign wr_hit[gi]  = WriteEnable && (WriteRegister   == AW'(gi)) && !IS_ZERO;
        assign res_hit[gi] = Reserve     && (ReserveRegister == AW'(gi)) && !IS_ZERO;

        // A reservation wins over a clearing write in the same cycle
        assign pend_d[gi] = res_hit[gi] | (pend_q[gi] & ~wr_hit[gi]);

        // Capture write data into this register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[gi] <= '0;
            end else if (wr_hit[gi]) begin
                regs_q[gi] <= WriteData;
            end
        end
    end

    // Scoreboard update for all registers at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign AnyPending = |pend_q;

    // Read ports: gather the two ports into arrays so one generate body serves both
    logic             rd_en   [2];
    logic [AW-1:0]    rd_addr [2];

    assign rd_en[0]   = ReadEnable1;
    assign rd_en[1]   = ReadEnable2;
    assign rd_addr[0] = ReadRegister1;
    assign rd_addr[1] = ReadRegister2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic             pend_rd_d;
        logic             pend_rd_q;

        // Select what this port would capture at the coming edge
        always_comb begin
            data_d    = regs_q[rd_addr[gi]];
            pend_rd_d = pend_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; pending reflects the post-edge state,
            // which is 0 unless a same-cycle reservation targets this register.
            if (WriteEnable && (WriteRegister == rd_addr[gi])) begin
                data_d    = WriteData;
                pend_rd_d = pend_d[rd_addr[gi]];
            end
`endif
            // Hardwired zero overrides any forwarding
            if ((R0_ZERO != 0) && (rd_addr[gi] == '0)) begin
                data_d    = '0;
                pend_rd_d = 1'b0;
            end
        end

        // Capture on enable, otherwise hold
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q    <= '0;
                pend_rd_q <= 1'b0;
            end else if (rd_en[gi]) begin
                data_q    <= data_d;
                pend_rd_q <= pend_rd_d;
            end
        end
    end

    assign ReadData1 = g_rd[0].data_q;
    assign ReadData2 = g_rd[1].data_q;
    assign Pending1  = g_rd[0].pend_rd_q;
    assign Pending2  = g_rd[1].pend_rd_q;

endmodule
